lc4_alu_result_stage: RTL

LC4_ALU_RESULT_STAGE -- requirements
Module: lc4_alu_result_stage

---
 rtl/lc4_alu_result_stage.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/lc4_alu_result_stage.sv
// LC4 ALU result stage: 2-entry in-order skid buffer that tags each result with
// its NZP code and divide-by-zero flag, and maintains the architectural CC register.
module lc4_alu_result_stage #(
    parameter logic [2:0]  CC_RESET  = 3'b010,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 o_in_ready,
    input  logic [15:0]          i_result,
    input  logic [15:0]          i_alu_ctl,
    input  logic [15:0]          i_b,
    input  logic [2:0]           i_rd,
    input  logic                 i_we,
    output logic                 o_valid,
    input  logic                 i_out_ready,
    output logic [15:0]          o_result,
    output logic [2:0]           o_rd,
    output logic                 o_we,
    output logic [2:0]           o_nzp,
    output logic                 o_err,
    output logic [2:0]           o_cc,
    output logic [ERR_CNT_W-1:0] o_err_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state, state_next;

    logic accept, deliver;
    logic load_head_in, load_head_skid, load_skid;

    logic [2:0] in_nzp;
    logic       in_err;

    logic [15:0] skid_result;
    logic [2:0]  skid_rd;
    logic        skid_we;
    logic [2:0]  skid_nzp;
    logic        skid_err;

    assign accept  = i_valid && o_in_ready;
    assign deliver = o_valid && i_out_ready;

    always_comb begin
        in_nzp = 3'b001;
        if (i_result[15])
            in_nzp = 3'b100;
        else if (i_result == '0)
            in_nzp = 3'b010;
        in_err = ((i_alu_ctl == 16'd3) || (i_alu_ctl == 16'd4)) && (i_b == '0);
    end

    always_comb begin
        state_next     = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_head_in = 1'b1;
                    state_next   = ONE;
                end
            end
            ONE: begin
                if (accept && deliver) begin
                    load_head_in = 1'b1;
                end else if (accept) begin
                    load_skid  = 1'b1;
                    state_next = TWO;
                end else if (deliver) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (deliver) begin
                    load_head_skid = 1'b1;
                    state_next     = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Ready/valid are registered from the next state so neither depends
    // combinationally on i_out_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= EMPTY;
            o_valid     <= 1'b0;
            o_in_ready  <= 1'b1;
            o_result    <= '0;
            o_rd        <= '0;
            o_we        <= 1'b0;
            o_nzp       <= '0;
            o_err       <= 1'b0;
            skid_result <= '0;
            skid_rd     <= '0;
            skid_we     <= 1'b0;
            skid_nzp    <= '0;
            skid_err    <= 1'b0;
            o_cc        <= CC_RESET;
            o_err_count <= '0;
        end else begin
            state      <= state_next;
            o_valid    <= (state_next != EMPTY);
            o_in_ready <= (state_next != TWO);

            if (load_head_in) begin
                o_result <= i_result;
                o_rd     <= i_rd;
                o_we     <= i_we;
                o_nzp    <= in_nzp;
                o_err    <= in_err;
            end else if (load_head_skid) begin
                o_result <= skid_result;
                o_rd     <= skid_rd;
                o_we     <= skid_we;
                o_nzp    <= skid_nzp;
                o_err    <= skid_err;
            end

            if (load_skid) begin
                skid_result <= i_result;
                skid_rd     <= i_rd;
                skid_we     <= i_we;
                skid_nzp    <= in_nzp;
                skid_err    <= in_err;
            end

            if (deliver && o_we)
                o_cc <= o_nzp;

            if (deliver && o_err && (o_err_count != '1))
                o_err_count <= o_err_count + ERR_CNT_W'(1);
        end
    end

endmodule
